// File: rtl/lsu_mem_arbiter_pkg.sv
// Shared types for the LSU data-memory arbiter: FSM encoding and bus slicing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int STALL_CNT_W = 32;

    // Low bit of channel idx inside a packed per-channel bus of the given width.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/lsu_mem_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin share of one data-memory port across NUM_CHANNELS LSU channels, one transaction at a time.
// Latency: write 3 cycles, read 4 cycles with a zero-wait memory. Optional stall counter: LSU_MEM_ARBITER_STALL_CNT_EN.
// Backpressure: request held on mem_req_rdy low; read response held on read_resp_rdy low; no new grant until IDLE.
module lsu_mem_arbiter
    import lsu_mem_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_WIDTH      = 16,
    parameter int DATA_ADDR_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    output logic [NUM_CHANNELS-1:0]                 read_req_rdy,
    input  logic [NUM_CHANNELS*DATA_ADDR_WIDTH-1:0] read_req_addr,
    input  logic [NUM_CHANNELS-1:0]                 read_req_addr_val,
    input  logic [NUM_CHANNELS-1:0]                 read_resp_rdy,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]      read_resp_data,
    output logic [NUM_CHANNELS-1:0]                 read_resp_data_val,
    output logic [NUM_CHANNELS-1:0]                 write_req_rdy,
    input  logic [NUM_CHANNELS*DATA_ADDR_WIDTH-1:0] write_req_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      write_req_data,
    input  logic [NUM_CHANNELS-1:0]                 write_req_val,
    output logic [NUM_CHANNELS-1:0]                 write_resp_val,
    output logic                                    mem_req_val,
    input  logic                                    mem_req_rdy,
    output logic                                    mem_req_we,
    output logic [DATA_ADDR_WIDTH-1:0]              mem_req_addr,
    output logic [DATA_WIDTH-1:0]                   mem_req_data,
    input  logic                                    mem_resp_val,
    input  logic [DATA_WIDTH-1:0]                   mem_resp_data,
`ifdef LSU_MEM_ARBITER_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0]                  stall_count,
`endif
    output logic                                    mem_resp_rdy
);

    localparam int N  = NUM_CHANNELS;
    localparam int DW = DATA_WIDTH;
    localparam int AW = DATA_ADDR_WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, g_q, g_idx, ptr_inc;
    logic [N-1:0]  req, gnt, own_q;
    logic          any_req, rd_sel, we_q, done;
    logic [AW-1:0] addr_q, sel_addr;
    logic [DW-1:0] data_q, sel_data, resp_q;

    // Requests are masked while reset is held so no rdy pulse leaks out of IDLE.
    assign req     = (read_req_addr_val | write_req_val) & {N{reset}};
    assign rd_sel  = |(gnt & read_req_addr_val);
    assign ptr_inc = (g_q == IW'(N - 1)) ? '0 : g_q + 1'b1;

    rr_arbiter #(.N(N), .IW(IW)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (g_idx),
        .any   (any_req)
    );

    always_comb begin : sel_mux
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_addr = rd_sel ? read_req_addr[slice_lo(i, AW) +: AW]
                                  : write_req_addr[slice_lo(i, AW) +: AW];
                sel_data = write_req_data[slice_lo(i, DW) +: DW];
            end
        end
    end

    always_comb begin : fsm
        state_nxt          = state;
        read_req_rdy       = '0;
        write_req_rdy      = '0;
        read_resp_data_val = '0;
        write_resp_val     = '0;
        mem_req_val        = 1'b0;
        mem_req_we         = 1'b0;
        mem_req_addr       = '0;
        mem_req_data       = '0;
        mem_resp_rdy       = 1'b0;
        done               = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (rd_sel) read_req_rdy  = gnt;
                    else        write_req_rdy = gnt;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_val  = 1'b1;
                mem_req_we   = we_q;
                mem_req_addr = addr_q;
                mem_req_data = data_q;
                if (mem_req_rdy) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                mem_resp_rdy = 1'b1;
                if (mem_resp_val) begin
                    if (we_q) begin
                        write_resp_val = own_q;
                        done           = 1'b1;
                        state_nxt      = ST_IDLE;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                read_resp_data_val = own_q;
                if (|(own_q & read_resp_rdy)) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin : resp_route
        read_resp_data = '0;
        for (int i = 0; i < N; i++) begin
            read_resp_data[slice_lo(i, DW) +: DW] = (state == ST_RESP && own_q[i]) ? resp_q : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ptr    <= '0;
            g_q    <= '0;
            own_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            resp_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                g_q    <= g_idx;
                own_q  <= gnt;
                we_q   <= !rd_sel;
                addr_q <= sel_addr;
                data_q <= rd_sel ? '0 : sel_data;
            end
            if (state == ST_WAIT && mem_resp_val && !we_q) begin
                resp_q <= mem_resp_data;
            end
            if (done) begin
                ptr <= ptr_inc;
            end
        end
    end

`ifdef LSU_MEM_ARBITER_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (any_req && !(|{read_req_rdy, write_req_rdy}) && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter with a zero-wait behavioural memory.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
module tb_lsu_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  rd_val, resp_rdy, wr_val;
    logic [31:0] rd_addr, wr_addr;
    logic [63:0] wr_data;
    logic [3:0]  read_req_rdy, read_resp_data_val, write_req_rdy, write_resp_val;
    logic [63:0] read_resp_data;
    logic        mem_req_val, mem_rdy, mem_req_we, mem_resp_val, mem_resp_rdy;
    logic [7:0]  mem_req_addr;
    logic [15:0] mem_req_data, mem_resp_data;
`ifdef LSU_MEM_ARBITER_STALL_CNT_EN
    logic [31:0] stall_count;
    logic [31:0] s0;
`endif

    logic [15:0] mem [0:255];
    logic [15:0] exp_rd [4];
    int          g_ch[$];
    bit          g_wr[$];
    int          n_checks, n_errors, wr_done;

    lsu_mem_arbiter dut (
        .clk                (clk),
        .reset              (reset),
        .read_req_rdy       (read_req_rdy),
        .read_req_addr      (rd_addr),
        .read_req_addr_val  (rd_val),
        .read_resp_rdy      (resp_rdy),
        .read_resp_data     (read_resp_data),
        .read_resp_data_val (read_resp_data_val),
        .write_req_rdy      (write_req_rdy),
        .write_req_addr     (wr_addr),
        .write_req_data     (wr_data),
        .write_req_val      (wr_val),
        .write_resp_val     (write_resp_val),
        .mem_req_val        (mem_req_val),
        .mem_req_rdy        (mem_rdy),
        .mem_req_we         (mem_req_we),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data       (mem_req_data),
        .mem_resp_val       (mem_resp_val),
        .mem_resp_data      (mem_resp_data),
`ifdef LSU_MEM_ARBITER_STALL_CNT_EN
        .stall_count        (stall_count),
`endif
        .mem_resp_rdy       (mem_resp_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory answers in the cycle after the request handshake; writes update the array.
    initial begin : mem_model
        bit          pend, pwe;
        logic [7:0]  paddr;
        pend = 0; pwe = 0; paddr = '0;
        mem_resp_val = 1'b0;
        mem_resp_data = '0;
        forever begin
            @(negedge clk);
            #1;
            mem_resp_val  = 1'b0;
            mem_resp_data = '0;
            if (pend) begin
                mem_resp_val  = 1'b1;
                mem_resp_data = pwe ? 16'h0 : mem[paddr];
                pend = 0;
            end
            if (mem_req_val && mem_rdy) begin
                pend  = 1;
                pwe   = mem_req_we;
                paddr = mem_req_addr;
                if (mem_req_we) mem[mem_req_addr] = mem_req_data;
            end
        end
    end

    // Called at a falling edge; channels drop a request the edge after its rdy pulse when
    // drop_on_grant is set, and everything is dropped once n_grants grants were seen.
    task automatic run_seq(input int n_grants, input bit drop_on_grant);
        int         seen, tail, cyc;
        logic [3:0] drd, dwr;
        seen = 0; tail = 0; cyc = 0; drd = '0; dwr = '0; wr_done = 0;
        g_ch.delete();
        g_wr.delete();
        while (tail < 6 && cyc < 80) begin
            #2;
            check_eq("excl", 64'($countones({read_req_rdy, write_req_rdy,
                                             read_resp_data_val, write_resp_val}) > 1), 64'h0);
            drd = drop_on_grant ? read_req_rdy  : 4'b0;
            dwr = drop_on_grant ? write_req_rdy : 4'b0;
            for (int i = 0; i < 4; i++) begin
                if (read_req_rdy[i])  begin g_ch.push_back(i); g_wr.push_back(1'b0); seen++; end
                if (write_req_rdy[i]) begin g_ch.push_back(i); g_wr.push_back(1'b1); seen++; end
                if (read_resp_data_val[i])
                    check_eq("rd_route", read_resp_data, 64'(exp_rd[i]) << (16 * i));
                if (write_resp_val[i]) wr_done++;
            end
            @(negedge clk);
            rd_val = rd_val & ~drd;
            wr_val = wr_val & ~dwr;
            if (seen >= n_grants) begin
                rd_val = '0;
                wr_val = '0;
                tail++;
            end
            cyc++;
        end
        check_eq("seq_grants", 64'(seen), 64'(n_grants));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int exp_ch[3];
        bit exp_wr[3];
        n_checks = 0; n_errors = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'hA500 | 16'(a);
        mem[8'h1A] = 16'hBEEF;
        mem[8'h33] = 16'h5A5A;
        for (int i = 0; i < 4; i++) mem[8'h40 + i] = 16'hC000 + 16'(i);
        for (int i = 0; i < 4; i++) exp_rd[i] = 16'hC000 + 16'(i);

        // Reset state, with every request line asserted.
        reset = 1'b0; rd_val = 4'hF; wr_val = 4'hF; resp_rdy = 4'hF; mem_rdy = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        #2;
        check_eq("rst_ctl", 64'({read_req_rdy, read_resp_data_val, write_req_rdy, write_resp_val,
                                 mem_req_val, mem_req_we, mem_req_addr, mem_req_data, mem_resp_rdy}), 64'h0);
        check_eq("rst_dat", read_resp_data, 64'h0);
        @(negedge clk); rd_val = '0; wr_val = '0;
        @(negedge clk); reset = 1'b1;

        // Single read, channel 2, zero-wait memory.
        @(negedge clk); rd_val = 4'b0100; rd_addr[23:16] = 8'h1A; #2;
        check_eq("rd_rdy_c0", 64'(read_req_rdy), 64'h4);
        @(negedge clk); rd_val = '0; #2;
        check_eq("rd_issue_val", 64'(mem_req_val), 64'h1);
        check_eq("rd_issue_we", 64'(mem_req_we), 64'h0);
        check_eq("rd_issue_addr", 64'(mem_req_addr), 64'h1A);
        @(negedge clk); #2;
        check_eq("rd_wait_rdy", 64'(mem_resp_rdy), 64'h1);
        check_eq("rd_wait_noval", 64'(read_resp_data_val), 64'h0);
        @(negedge clk); #2;
        check_eq("rd_val_c3", 64'(read_resp_data_val), 64'h4);
        check_eq("rd_data_c3", read_resp_data, 64'h0000_BEEF_0000_0000);

        // Single write, channel 0.
        @(negedge clk); wr_val = 4'b0001; wr_addr[7:0] = 8'h05; wr_data[15:0] = 16'h1234; #2;
        check_eq("wr_rdy_c0", 64'({read_req_rdy, write_req_rdy}), 64'h01);
        @(negedge clk); wr_val = '0; #2;
        check_eq("wr_issue", 64'({mem_req_val, mem_req_we, mem_req_addr, mem_req_data}), 64'h3_05_1234);
        @(negedge clk); #2;
        check_eq("wr_resp_c2", 64'(write_resp_val), 64'h1);
        @(negedge clk); #2;
        check_eq("wr_resp_c3", 64'(write_resp_val), 64'h0);
        check_eq("wr_mem", 64'(mem[8'h05]), 64'h1234);

        // Reset while a channel-3 read waits on memory: the response is dropped.
        @(negedge clk); rd_val = 4'b1000; rd_addr[31:24] = 8'h50; #2;
        check_eq("rw_grant3", 64'(read_req_rdy), 64'h8);
        @(negedge clk); rd_val = '0; #2;
        check_eq("rw_issue", 64'(mem_req_val), 64'h1);
        @(negedge clk); reset = 1'b0; #2;
        check_eq("rw_rst_ctl", 64'({read_req_rdy, read_resp_data_val, write_req_rdy, write_resp_val,
                                    mem_req_val, mem_req_we, mem_req_addr, mem_req_data, mem_resp_rdy}), 64'h0);
        @(negedge clk); reset = 1'b1; #2;
        check_eq("rw_noresp0", 64'(read_resp_data_val), 64'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #2;
            check_eq("rw_noresp", 64'(read_resp_data_val), 64'h0);
        end

        // All four channels hold reads; pointer restarts at 0 after reset.
        @(negedge clk); rd_val = 4'hF; rd_addr = 32'h4342_4140;
        run_seq(5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k < g_ch.size()) begin
                check_eq("rr_order_ch", 64'(g_ch[k]), 64'(k % 4));
                check_eq("rr_order_rd", 64'(g_wr[k]), 64'h0);
            end
        end

        // Backpressure: memory stalls 5 cycles, channel 1 stalls the response 3 cycles.
        mem_rdy = 1'b0; rd_val = 4'b0110; rd_addr[15:8] = 8'h33; rd_addr[23:16] = 8'h44; resp_rdy[1] = 1'b0; #2;
        check_eq("bp_grant1", 64'(read_req_rdy), 64'h2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) rd_val[1] = 1'b0;
            if (k == 5) mem_rdy = 1'b1;
            #2;
            check_eq("bp_req_val", 64'(mem_req_val), 64'h1);
            check_eq("bp_req_addr", 64'(mem_req_addr), 64'h33);
            check_eq("bp_no_grant", 64'(read_req_rdy), 64'h0);
        end
        @(negedge clk); #2;
        check_eq("bp_wait", 64'(mem_resp_rdy), 64'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) resp_rdy[1] = 1'b1;
            #2;
            check_eq("bp_resp_val", 64'(read_resp_data_val), 64'h2);
            check_eq("bp_resp_data", read_resp_data, 64'h0000_0000_5A5A_0000);
            check_eq("bp_no_grant2", 64'(read_req_rdy), 64'h0);
        end
        @(negedge clk); #2;
        check_eq("bp_next_grant", 64'(read_req_rdy), 64'h4);
        @(negedge clk); rd_val = '0;
        repeat (4) @(negedge clk);

        // Channel 1 read+write with channel 2 read pending; pointer is 3 here.
`ifdef LSU_MEM_ARBITER_STALL_CNT_EN
        s0 = stall_count;
`endif
        rd_val = 4'b0110; wr_val = 4'b0010;
        rd_addr[15:8] = 8'h41; rd_addr[23:16] = 8'h42;
        wr_addr[15:8] = 8'h60; wr_data[31:16] = 16'h7777;
        run_seq(3, 1'b1);
        exp_ch = '{1, 2, 1};
        exp_wr = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            if (k < g_ch.size()) begin
                check_eq("rw_order_ch", 64'(g_ch[k]), 64'(exp_ch[k]));
                check_eq("rw_order_wr", 64'(g_wr[k]), 64'(exp_wr[k]));
            end
        end
        check_eq("rw_wr_done", 64'(wr_done), 64'h1);
        check_eq("rw_wr_mem", 64'(mem[8'h60]), 64'h7777);
`ifdef LSU_MEM_ARBITER_STALL_CNT_EN
        check_eq("stall_cnt", 64'(stall_count - s0), 64'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
